// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - HybridCore execute stage: ALU, divider, memory/stack, branch, NZCV
module exec_stage #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = 5,
    parameter logic [ADDR_W-1:0] SP_INIT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic [DATA_W-1:0]    in_a,
    input  logic [DATA_W-1:0]    in_b,
    input  logic [REG_IDX_W-1:0] in_dst,
    input  logic [3:0]           in_cond,
    input  logic [ADDR_W-1:0]    in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_result,
    output logic [REG_IDX_W-1:0] out_dst,
    output logic                 out_wb_en,
    output logic [3:0]           flags,
    output logic [ADDR_W-1:0]    sp,
    output logic                 branch_en,
    output logic [ADDR_W-1:0]    branch_target,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_ack
);
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_MUL = 5'b00010,
                           OP_DIV = 5'b00011, OP_AND = 5'b00100, OP_NAND = 5'b00101,
                           OP_OR  = 5'b00110, OP_NOR = 5'b00111, OP_XOR = 5'b01000,
                           OP_XNOR = 5'b01001, OP_SHL = 5'b01010, OP_SHR = 5'b01011,
                           OP_ROL = 5'b01100, OP_ROR = 5'b01101, OP_ASR = 5'b01110,
                           OP_CMP = 5'b01111, OP_MOV = 5'b10000, OP_LOAD = 5'b10010,
                           OP_STORE = 5'b10011, OP_MSR = 5'b10100, OP_MRS = 5'b10101,
                           OP_PUSH = 5'b10110, OP_POP = 5'b10111, OP_B = 5'b11000,
                           OP_CALL = 5'b11010, OP_RET = 5'b11011;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_MEM, S_DONE} state_t;
    state_t state_q, state_d;

    logic [4:0]           op_q;
    logic [DATA_W-1:0]    result_q;
    logic [REG_IDX_W-1:0] dst_q;
    logic                 wb_q;
    logic [3:0]           flags_q;
    logic [ADDR_W-1:0]    sp_q;
    logic                 branch_q;
    logic [ADDR_W-1:0]    target_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic                 mem_we_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic [DATA_W-1:0]    rem_q, quo_q, divisor_q;
    logic [SH_W-1:0]      div_cnt_q;
    logic                 div_zero_q;

    logic accept, is_div, is_mem;
    logic [SH_W-1:0]     sh;
    logic [DATA_W:0]     sum, diff, shl_ext, shr_ext, asr_ext;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_v;
    logic [3:0]          alu_flags;
    logic [DATA_W:0]     div_shift, div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   div_quo_n, pc_ret, mrs_res;
    logic [ADDR_W-1:0]   sp_dec, sp_inc;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: cond_ok = 1'b1;
            4'h1: cond_ok = z;
            4'h2: cond_ok = !z;
            4'h3: cond_ok = cf;
            4'h4: cond_ok = !cf;
            4'h5: cond_ok = n;
            4'h6: cond_ok = !n;
            4'h7: cond_ok = v;
            4'h8: cond_ok = !v;
            4'h9: cond_ok = cf && !z;
            4'hA: cond_ok = !cf || z;
            4'hB: cond_ok = (n == v);
            4'hC: cond_ok = (n != v);
            4'hD: cond_ok = !z && (n == v);
            4'hE: cond_ok = z || (n != v);
            default: cond_ok = 1'b0;
        endcase
    endfunction

    always_comb begin
        is_div = (in_op == OP_DIV);
        is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE) || (in_op == OP_PUSH) ||
                 (in_op == OP_POP) || (in_op == OP_CALL) || (in_op == OP_RET);
        accept = in_valid && in_ready;
        sp_dec = sp_q - ADDR_W'(1);
        sp_inc = sp_q + ADDR_W'(1);
        pc_ret = '0;
        pc_ret[ADDR_W-1:0] = in_pc + ADDR_W'(1);
        mrs_res = '0;
        mrs_res[3:0] = flags_q;
    end

    // Shift carries come from one extra bit carried alongside the operand.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sh      = in_b[SH_W-1:0];
        sum     = {1'b0, in_a} + {1'b0, in_b};
        diff    = {1'b0, in_a} - {1'b0, in_b};
        prod    = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
        shl_ext = {1'b0, in_a} << sh;
        shr_ext = {in_a, 1'b0} >> sh;
        asr_ext = $unsigned($signed({in_a, 1'b0}) >>> sh);
        case (in_op)
            OP_ADD: begin
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[MSB:0];
                alu_c   = !diff[DATA_W];
                alu_v   = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_a[MSB]);
            end
            OP_MUL: begin
                alu_res = prod[MSB:0];
                alu_v   = |prod[2*DATA_W-1:DATA_W];
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_NAND: alu_res = ~(in_a & in_b);
            OP_OR:   alu_res = in_a | in_b;
            OP_NOR:  alu_res = ~(in_a | in_b);
            OP_XOR:  alu_res = in_a ^ in_b;
            OP_XNOR: alu_res = ~(in_a ^ in_b);
            OP_SHL: begin
                alu_res = shl_ext[MSB:0];
                alu_c   = shl_ext[DATA_W];
            end
            OP_SHR: begin
                alu_res = shr_ext[DATA_W:1];
                alu_c   = shr_ext[0];
            end
            OP_ASR: begin
                alu_res = asr_ext[DATA_W:1];
                alu_c   = asr_ext[0];
            end
            OP_ROL: begin
                alu_res = (in_a << sh) | (in_a >> (DATA_W - int'(sh)));
                alu_c   = (sh != '0) && alu_res[0];
            end
            OP_ROR: begin
                alu_res = (in_a >> sh) | (in_a << (DATA_W - int'(sh)));
                alu_c   = (sh != '0) && alu_res[MSB];
            end
            default: ;
        endcase
        alu_flags = {alu_res[MSB], alu_res == '0, alu_c, alu_v};
    end

    // Partial remainder stays below 2*divisor, so the borrow bit is the compare result.
    always_comb begin
        div_shift = {rem_q, quo_q[MSB]};
        div_diff  = div_shift - {1'b0, divisor_q};
        div_ge    = !div_diff[DATA_W];
        div_quo_n = {quo_q[MSB-1:0], div_ge};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = (state_q == S_IDLE) && !reset;
        out_valid = (state_q == S_DONE);
        mem_req   = (state_q == S_MEM);
        case (state_q)
            S_IDLE: if (accept) state_d = is_div ? S_DIV : (is_mem ? S_MEM : S_DONE);
            S_DIV:  if (div_cnt_q == '0) state_d = S_DONE;
            S_MEM:  if (mem_ack) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0; result_q <= '0; dst_q <= '0; wb_q <= 1'b0;
            flags_q <= '0; sp_q <= SP_INIT; branch_q <= 1'b0; target_q <= '0;
            mem_addr_q <= '0; mem_we_q <= 1'b0; mem_wdata_q <= '0;
            rem_q <= '0; quo_q <= '0; divisor_q <= '0; div_cnt_q <= '0; div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    op_q        <= in_op;
                    dst_q       <= in_dst;
                    result_q    <= '0;
                    wb_q        <= 1'b0;
                    branch_q    <= 1'b0;
                    target_q    <= in_a[ADDR_W-1:0];
                    mem_we_q    <= 1'b0;
                    mem_wdata_q <= in_b;
                    mem_addr_q  <= in_b[ADDR_W-1:0];
                    if (!in_op[4] && !is_div) begin
                        result_q <= alu_res;
                        flags_q  <= alu_flags;
                        wb_q     <= (in_op != OP_CMP);
                    end
                    case (in_op)
                        OP_DIV: begin
                            rem_q      <= '0;
                            quo_q      <= in_a;
                            divisor_q  <= in_b;
                            div_cnt_q  <= SH_W'(DATA_W - 1);
                            div_zero_q <= (in_b == '0);
                            wb_q       <= 1'b1;
                        end
                        OP_MOV:   begin result_q <= in_b; wb_q <= 1'b1; end
                        OP_LOAD:  wb_q <= 1'b1;
                        OP_STORE: begin mem_addr_q <= in_a[ADDR_W-1:0]; mem_we_q <= 1'b1; end
                        OP_MSR:   flags_q <= in_b[3:0];
                        OP_MRS:   begin result_q <= mrs_res; wb_q <= 1'b1; end
                        OP_PUSH:  begin mem_addr_q <= sp_dec; mem_we_q <= 1'b1; end
                        OP_POP:   begin mem_addr_q <= sp_q; wb_q <= 1'b1; end
                        OP_B:     branch_q <= cond_ok(in_cond, flags_q);
                        OP_CALL: begin
                            mem_addr_q  <= sp_dec;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= pc_ret;
                            branch_q    <= 1'b1;
                        end
                        OP_RET:   mem_addr_q <= sp_q;
                        default: ;
                    endcase
                end
                S_DIV: begin
                    rem_q     <= div_ge ? div_diff[MSB:0] : div_shift[MSB:0];
                    quo_q     <= div_quo_n;
                    div_cnt_q <= div_cnt_q - SH_W'(1);
                    if (div_cnt_q == '0) begin
                        result_q <= div_quo_n;
                        flags_q  <= {div_quo_n[MSB], div_quo_n == '0, 1'b0, div_zero_q};
                    end
                end
                S_MEM: if (mem_ack) begin
                    if (!mem_we_q) result_q <= mem_rdata;
                    case (op_q)
                        OP_PUSH, OP_CALL: sp_q <= sp_dec;
                        OP_POP:           sp_q <= sp_inc;
                        OP_RET: begin
                            sp_q     <= sp_inc;
                            branch_q <= 1'b1;
                            target_q <= mem_rdata[ADDR_W-1:0];
                        end
                        default: ;
                    endcase
                end
                // Clearing on every DONE edge makes branch_en a single-cycle pulse.
                S_DONE: branch_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_result    = result_q;
    assign out_dst       = dst_q;
    assign out_wb_en     = out_valid && wb_q;
    assign flags         = flags_q;
    assign sp            = sp_q;
    assign branch_en     = out_valid && branch_q;
    assign branch_target = target_q;
    assign mem_we        = mem_req && mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - scoreboard bench for exec_stage with a delayed-ack memory model
module tb_exec_stage;
    logic        clk = 1'b0, reset = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [4:0]  in_op = '0;
    logic [15:0] in_a = '0, in_b = '0, in_pc = '0;
    logic [4:0]  in_dst = '0;
    logic [3:0]  in_cond = '0;
    logic        out_valid, out_ready = 1'b1, out_wb_en;
    logic [15:0] out_result;
    logic [4:0]  out_dst;
    logic [3:0]  flags;
    logic [15:0] sp, branch_target, mem_addr, mem_wdata;
    logic        branch_en, mem_req, mem_we, mem_ack;
    logic [15:0] mem_rdata = '0;
    logic        resp_ack = 1'b0, manual_ack = 1'b0;

    assign mem_ack = resp_ack | manual_ack;

    exec_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dst(in_dst), .in_cond(in_cond), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_dst(out_dst),
        .out_wb_en(out_wb_en), .flags(flags), .sp(sp), .branch_en(branch_en),
        .branch_target(branch_target), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic        chk;
        logic [15:0] res;
        logic [4:0]  dst;
        logic        wb;
        logic [3:0]  fl;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] spv;
        int          lat;
        int          acc;
    } exp_t;
    typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } mexp_t;

    exp_t  exp_q[$];
    mexp_t mexp_q[$];

    // Memory responder: acks after ack_delay cycles of mem_req, checks each access
    logic [15:0] mem [0:65535];
    int          ack_delay = 0, wcnt = 0;
    logic        resp_en = 1'b1, mstable;
    logic [15:0] ma0, md0;
    logic        mw0;
    always @(negedge clk) begin
        if (resp_en && mem_req) begin
            if (wcnt == 0) begin
                ma0 = mem_addr; mw0 = mem_we; md0 = mem_wdata; mstable = 1'b1;
            end else if (mem_addr !== ma0 || mem_we !== mw0 || mem_wdata !== md0) begin
                mstable = 1'b0;
            end
            if (wcnt == ack_delay) begin
                mexp_t m;
                resp_ack  = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we) mem[mem_addr] = mem_wdata;
                if (mexp_q.size() == 0) begin
                    check("unexpected_mem_access", 1, 0);
                end else begin
                    m = mexp_q.pop_front();
                    check("mem_addr", mem_addr, m.addr);
                    check("mem_we", mem_we, m.we);
                    if (m.we) check("mem_wdata", mem_wdata, m.wdata);
                    if (wcnt > 0) check("mem_stable", mstable, 1);
                end
            end else begin
                resp_ack = 1'b0;
            end
            wcnt++;
        end else begin
            resp_ack = 1'b0;
            wcnt = 0;
        end
    end

    // Monitor: pops one expectation per result and checks it at the handshake
    exp_t        cur;
    logic        in_done = 1'b0, have_exp = 1'b0, stable;
    int          br_cnt, dcyc;
    logic [15:0] s_res, s_tgt, s_sp, seen_tgt;
    logic [4:0]  s_dst;
    logic [3:0]  s_fl;
    logic        s_wb;
    always @(negedge clk) begin
        if (reset) begin
            in_done = 1'b0;
        end else if (out_valid) begin
            if (!in_done) begin
                in_done = 1'b1; br_cnt = 0; dcyc = 0; stable = 1'b1; seen_tgt = '0;
                s_res = out_result; s_dst = out_dst; s_wb = out_wb_en; s_fl = flags;
                s_tgt = branch_target; s_sp = sp;
                if (exp_q.size() == 0) begin
                    have_exp = 1'b0;
                    check("unexpected_output", 1, 0);
                end else begin
                    have_exp = 1'b1;
                    cur = exp_q.pop_front();
                    if (cur.lat > 0) check($sformatf("v%0d_latency", cur.id), cyc - cur.acc, cur.lat);
                end
            end else if (out_result !== s_res || out_dst !== s_dst || out_wb_en !== s_wb ||
                         flags !== s_fl || branch_target !== s_tgt || sp !== s_sp) begin
                stable = 1'b0;
            end
            dcyc++;
            if (branch_en) begin
                br_cnt++;
                seen_tgt = branch_target;
            end
            if (out_ready) begin
                if (have_exp) begin
                    if (cur.chk) check($sformatf("v%0d_result", cur.id), out_result, cur.res);
                    if (cur.wb) check($sformatf("v%0d_dst", cur.id), out_dst, cur.dst);
                    check($sformatf("v%0d_wb_en", cur.id), out_wb_en, cur.wb);
                    check($sformatf("v%0d_flags", cur.id), flags, cur.fl);
                    check($sformatf("v%0d_sp", cur.id), sp, cur.spv);
                    check($sformatf("v%0d_branch_pulses", cur.id), br_cnt, cur.br ? 1 : 0);
                    if (cur.br) check($sformatf("v%0d_branch_target", cur.id), seen_tgt, cur.tgt);
                    if (dcyc > 1) check($sformatf("v%0d_frozen", cur.id), stable, 1);
                end
                in_done = 1'b0;
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] dst, input logic [3:0] cond, input logic [15:0] pc,
                         input exp_t e, input logic push);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) check("issue_timeout", 0, 1);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dst = dst; in_cond = cond; in_pc = pc;
        e.acc = cyc;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    int vid = 0;
    task automatic run(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [4:0] dst, input logic [3:0] cond, input logic [15:0] pc,
                       input logic chk, input logic [15:0] res, input logic wb, input logic [3:0] fl,
                       input logic br, input logic [15:0] tgt, input logic [15:0] spv, input int lat);
        exp_t e;
        vid++;
        e.id = vid; e.chk = chk; e.res = res; e.dst = dst; e.wb = wb; e.fl = fl;
        e.br = br; e.tgt = tgt; e.spv = spv; e.lat = lat; e.acc = 0;
        issue(op, a, b, dst, cond, pc, e, 1'b1);
    endtask

    task automatic mexp(input logic [15:0] addr, input logic we, input logic [15:0] wdata);
        mexp_t m;
        m.addr = addr; m.we = we; m.wdata = wdata;
        mexp_q.push_back(m);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || in_done) && g < 300) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0 || in_done) check("drain_timeout", 0, 1);
    endtask

    initial begin
        exp_t dummy;
        int g;
        dummy.id = 0; dummy.chk = 0; dummy.res = '0; dummy.dst = '0; dummy.wb = 0; dummy.fl = '0;
        dummy.br = 0; dummy.tgt = '0; dummy.spv = '0; dummy.lat = 0; dummy.acc = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_flags", flags, 0);
        check("rst_sp", sp, 16'hFFFF);
        check("rst_mem_req", mem_req, 0);
        check("rst_branch_en", branch_en, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        //   op        a        b        dst    cond   pc       chk res      wb fl       br tgt      sp       lat
        run(5'b00000, 16'h7FFF, 16'h0001, 5'd1, 4'h0, 16'h0, 1, 16'h8000, 1, 4'b1001, 0, 16'h0, 16'hFFFF, 1);
        run(5'b01111, 16'h0003, 16'h0005, 5'd2, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1000, 0, 16'h0, 16'hFFFF, 1);
        run(5'b11000, 16'h0040, 16'h0000, 5'd0, 4'hC, 16'h0, 0, 16'h0000, 0, 4'b1000, 1, 16'h0040, 16'hFFFF, 1);
        run(5'b11000, 16'h0040, 16'h0000, 5'd0, 4'hB, 16'h0, 0, 16'h0000, 0, 4'b1000, 0, 16'h0, 16'hFFFF, 1);
        run(5'b00011, 16'h00C8, 16'h0007, 5'd5, 4'h0, 16'h0, 1, 16'h001C, 1, 4'b0000, 0, 16'h0, 16'hFFFF, 17);
        run(5'b00011, 16'h1234, 16'h0000, 5'd6, 4'h0, 16'h0, 1, 16'hFFFF, 1, 4'b1001, 0, 16'h0, 16'hFFFF, 17);
        run(5'b00001, 16'h0005, 16'h0005, 5'd7, 4'h0, 16'h0, 1, 16'h0000, 1, 4'b0110, 0, 16'h0, 16'hFFFF, 1);
        run(5'b01010, 16'h8001, 16'h0001, 5'd8, 4'h0, 16'h0, 1, 16'h0002, 1, 4'b0010, 0, 16'h0, 16'hFFFF, 1);
        run(5'b01101, 16'h0001, 16'h0004, 5'd9, 4'h0, 16'h0, 1, 16'h1000, 1, 4'b0000, 0, 16'h0, 16'hFFFF, 1);
        run(5'b01110, 16'h8000, 16'h000F, 5'd10, 4'h0, 16'h0, 1, 16'hFFFF, 1, 4'b1000, 0, 16'h0, 16'hFFFF, 1);
        run(5'b00010, 16'h0100, 16'h0100, 5'd11, 4'h0, 16'h0, 1, 16'h0000, 1, 4'b0101, 0, 16'h0, 16'hFFFF, 1);
        run(5'b10000, 16'h0000, 16'hABCD, 5'd12, 4'h0, 16'h0, 1, 16'hABCD, 1, 4'b0101, 0, 16'h0, 16'hFFFF, 1);
        run(5'b10101, 16'h0000, 16'h0000, 5'd13, 4'h0, 16'h0, 1, 16'h0005, 1, 4'b0101, 0, 16'h0, 16'hFFFF, 1);
        run(5'b10100, 16'h0000, 16'h000A, 5'd0, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 0, 16'h0, 16'hFFFF, 1);
        run(5'b11000, 16'h0200, 16'h0000, 5'd0, 4'h3, 16'h0, 0, 16'h0000, 0, 4'b1010, 1, 16'h0200, 16'hFFFF, 1);
        run(5'b10001, 16'h1111, 16'h2222, 5'd14, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 0, 16'h0, 16'hFFFF, 1);

        drain(); ack_delay = 1;
        mexp(16'h0010, 1, 16'h5555);
        run(5'b10011, 16'h0010, 16'h5555, 5'd0, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 0, 16'h0, 16'hFFFF, 3);
        mexp(16'h0010, 0, 16'h0000);
        run(5'b10010, 16'h0000, 16'h0010, 5'd4, 4'h0, 16'h0, 1, 16'h5555, 1, 4'b1010, 0, 16'h0, 16'hFFFF, 3);

        drain(); ack_delay = 3;
        mexp(16'hFFFE, 1, 16'h1234);
        run(5'b10110, 16'h0000, 16'h1234, 5'd0, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 0, 16'h0, 16'hFFFE, 5);
        mexp(16'hFFFE, 0, 16'h0000);
        run(5'b10111, 16'h0000, 16'h0000, 5'd3, 4'h0, 16'h0, 1, 16'h1234, 1, 4'b1010, 0, 16'h0, 16'hFFFF, 5);

        drain(); ack_delay = 0;
        out_ready = 1'b0;
        mexp(16'hFFFE, 1, 16'h0021);
        run(5'b11010, 16'h0100, 16'h0000, 5'd0, 4'h0, 16'h0020, 0, 16'h0000, 0, 4'b1010, 1, 16'h0100, 16'hFFFE, 2);
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk);
            g++;
        end
        if (!out_valid) check("call_valid_timeout", 0, 1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        mexp(16'hFFFE, 0, 16'h0000);
        run(5'b11011, 16'h0000, 16'h0000, 5'd0, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 1, 16'h0021, 16'hFFFF, 2);

        drain();
        mexp(16'hFFFE, 1, 16'h7777);
        run(5'b10110, 16'h0000, 16'h7777, 5'd0, 4'h0, 16'h0, 0, 16'h0000, 0, 4'b1010, 0, 16'h0, 16'hFFFE, 2);
        drain();
        resp_en = 1'b0;
        issue(5'b10010, 16'h0000, 16'h0010, 5'd4, 4'h0, 16'h0, dummy, 1'b0);
        repeat (3) @(negedge clk);
        check("mem_wait_req", mem_req, 1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        check("reset_drops_mem_req", mem_req, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_sp", sp, 16'hFFFF);
        check("reset_flags", flags, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #1 manual_ack = 1'b1;
        @(posedge clk); #1 manual_ack = 1'b0;
        @(negedge clk);
        check("late_ack_mem_req", mem_req, 0);
        check("late_ack_out_valid", out_valid, 0);
        check("late_ack_in_ready", in_ready, 1);
        resp_en = 1'b1;
        run(5'b00000, 16'h0002, 16'h0003, 5'd15, 4'h0, 16'h0, 1, 16'h0005, 1, 4'b0000, 0, 16'h0, 16'hFFFF, 1);
        drain();
        check("mem_queue_empty", mexp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
